// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: transfer size codes,
// FSM states and the wrapped priority search behind the grant picker.
package bus_pkg;

  localparam int IW = 3;

  typedef enum logic [1:0] {
    SIZ_BYTE  = 2'd0,
    SIZ_HALF  = 2'd1,
    SIZ_WORD  = 2'd2,
    SIZ_DWORD = 2'd3
  } siz_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Returns {found, index} of the first set bit in req[n-1:0] after last, wrapping to 0.
  function automatic logic [IW:0] rr_search(input logic [7:0]    req,
                                            input logic [IW-1:0] last,
                                            input logic [IW:0]   n);
    logic [IW:0] res;
    logic [IW:0] idx;
    res = {(IW+1){1'b0}};
    for (int i = 1; i <= 8; i++) begin
      idx = {1'b0, last} + (IW+1)'(i);
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if (((IW+1)'(i) <= n) && !res[IW] && req[idx[IW-1:0]]) begin
        res = {1'b1, idx[IW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: selects the first requester after the
// last-granted index, wrapping from N-1 back to 0.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] res_s;
  logic [7:0]  req_s;

  assign req_s = 8'(req);
  assign res_s = rr_search(req_s, last, (IW+1)'(N));
  assign any   = res_s[IW];
  assign idx   = res_s[IW-1:0];

  // One-hot decode of the winning index.
  always_comb begin
    gnt = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      gnt[k] = any && (idx == IW'(k));
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master round-robin arbiter onto one external bus. The grant is locked for
// the owner's whole cyc tenure; a strobe stalled too long is answered with err.
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int MASTERS = 2,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [MASTERS*DW-1:0] m_dat_i,
  input  logic [MASTERS*AW-1:0] m_adr_i,
  input  logic [MASTERS-1:0]   m_we_i,
  input  logic [MASTERS-1:0]   m_cyc_i,
  input  logic [MASTERS-1:0]   m_stb_i,
  input  logic [2*MASTERS-1:0] m_siz_i,
  input  logic [MASTERS-1:0]   m_signed_i,
  output logic [MASTERS-1:0]   m_ack_o,
  output logic [MASTERS-1:0]   m_err_o,
  output logic [DW-1:0]        m_dat_o,
  output logic [MASTERS-1:0]   gnt_o,
  output logic [DW-1:0]        x_dat_o,
  output logic [AW-1:0]        x_adr_o,
  output logic                 x_we_o,
  output logic                 x_cyc_o,
  output logic                 x_stb_o,
  output logic [1:0]           x_siz_o,
  output logic                 x_signed_o,
  input  logic                 x_ack_i,
  input  logic [DW-1:0]        x_dat_i
);

  state_t             state_r, state_n_s;
  logic [MASTERS-1:0] gnt_r, gnt_n_s;
  logic [IW-1:0]      ptr_r, ptr_n_s;
  logic [CW-1:0]      cnt_r, cnt_n_s;
  logic [MASTERS-1:0] pick_gnt_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic               own_cyc_s, own_stb_s, stall_s, tmo_hit_s;

  rr_pick #(.N(MASTERS)) u_pick (
    .req  (m_cyc_i),
    .last (ptr_r),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // gnt_r is non-zero only in OWN, so these reduce to zero while idle.
  assign own_cyc_s = |(gnt_r & m_cyc_i);
  assign own_stb_s = |(gnt_r & m_cyc_i & m_stb_i);
  assign stall_s   = (TIMEOUT > 0) && own_stb_s && !x_ack_i;
  assign tmo_hit_s = stall_s && (cnt_r == CW'(TIMEOUT - 1));

  // State, grant, last-grant pointer and stall counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
      gnt_r   <= {MASTERS{1'b0}};
      ptr_r   <= IW'(MASTERS - 1);
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_n_s;
      gnt_r   <= gnt_n_s;
      ptr_r   <= ptr_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Arbitrate in IDLE, hold the grant while the owner keeps cyc, count stalls.
  always_comb begin
    state_n_s = state_r;
    gnt_n_s   = gnt_r;
    ptr_n_s   = ptr_r;
    cnt_n_s   = {CW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_n_s = ST_OWN;
          gnt_n_s   = pick_gnt_s;
          ptr_n_s   = pick_idx_s;
        end else begin
          state_n_s = ST_IDLE;
          gnt_n_s   = {MASTERS{1'b0}};
        end
      end
      ST_OWN: begin
        if (!own_cyc_s) begin
          state_n_s = ST_IDLE;
          gnt_n_s   = {MASTERS{1'b0}};
        end else if (stall_s && !tmo_hit_s) begin
          cnt_n_s = cnt_r + CW'(1'b1);
        end else begin
          cnt_n_s = {CW{1'b0}};
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        gnt_n_s   = {MASTERS{1'b0}};
      end
    endcase
  end

  // Steer the owner's request onto the external bus and route ack/err back.
  always_comb begin
    x_dat_o    = {DW{1'b0}};
    x_adr_o    = {AW{1'b0}};
    x_we_o     = 1'b0;
    x_siz_o    = 2'b00;
    x_signed_o = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      if (gnt_r[k]) begin
        x_dat_o    = x_dat_o | m_dat_i[k*DW +: DW];
        x_adr_o    = x_adr_o | m_adr_i[k*AW +: AW];
        x_we_o     = x_we_o | m_we_i[k];
        x_siz_o    = x_siz_o | m_siz_i[k*2 +: 2];
        x_signed_o = x_signed_o | m_signed_i[k];
      end else begin
        x_dat_o = x_dat_o;
      end
    end
    x_cyc_o = own_cyc_s;
    x_stb_o = own_stb_s;
    m_ack_o = gnt_r & {MASTERS{x_ack_i}};
    m_err_o = gnt_r & {MASTERS{tmo_hit_s}};
  end

  assign m_dat_o = x_dat_i;
  assign gnt_o   = gnt_r;

endmodule
